imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Single-port instruction-memory arbiter between the CPU fetch stage and a host loader (debug/boot port). It grants one access per cycle to the 4096×32 instruction RAM and steers the one-cycle-later read data back to its owner. It also stalls the CPU on lost arbitration. A host lock/flush sequence lets the host rewrite program memory while the CPU is held, then forces a refetch.

## Interface
Parameters:
- ADDR_W, 12, word address width (4096 words)
- DATA_W, 32, data width
- MAX_HOST_BURST, 8, consecutive host grants allowed while fetch waits (1..255)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- fetch_req  in  1  fetch stage requests a read
- fetch_addr  in  ADDR_W  fetch word address (PC)
- fetch_gnt  out  1  fetch access issued this cycle
- fetch_rvalid  out  1  fetch read data valid
- fetch_rdata  out  DATA_W  instruction word; 0 when fetch_rvalid low
- host_req  in  1  host access request
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host word address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  host access issued this cycle
- host_rvalid  out  1  host read data valid
- host_rdata  out  DATA_W  host read data; 0 when host_rvalid low
- host_lock  in  1  host exclusive ownership; CPU held
- cpu_stall  out  1  hold PC_FETCH/instruction_EX
- cpu_flush  out  1  one-cycle pulse: discard instruction_EX, refetch current PC
- ram_en, ram_we  out  1  RAM enable / write enable
- ram_addr  out  ADDR_W; ram_wdata  out  DATA_W  RAM address / write data
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_en

## Operation
- FSM states: RUN, LOCK, FLUSH. Reset state RUN.
- RUN → LOCK when host_lock=1 at a clock edge. LOCK → FLUSH when host_lock=0. FLUSH → RUN unconditionally after one cycle.
- Fetch eligible only in RUN with host_lock=0. The input is masked combinationally, so the first cycle of lock already denies fetch.
- Host is eligible in RUN and LOCK. Host is never granted in FLUSH.
- Conflict resolution in RUN (both eligible):
  - Host wins while burst_cnt < MAX_HOST_BURST.
  - Otherwise fetch wins and burst_cnt clears.
- burst_cnt (8-bit):
  - Increments on each host grant while fetch_req=1 and fetch is denied.
  - Clears on a fetch grant, or when fetch_req=0.
  - Held at 0 in LOCK/FLUSH.
- Sole eligible requester always granted. Grants are one-hot or both zero.
- RAM port mux is driven from the winner:
  - ram_en = gnt.
  - ram_we = host_gnt & host_we.
  - Unused fields are driven 0.
- Owner register captures {fetch_gnt, host_gnt & ~host_we} each edge. Next cycle it raises the matching rvalid and routes ram_rdata to that owner. Host writes produce no rvalid.
- cpu_stall = (fetch_req & ~fetch_gnt) | (state≠RUN) | host_lock.
- cpu_flush = (state==FLUSH).

## Timing
- Grants, ram_*, and cpu_stall are combinational from inputs and registered state: zero-cycle issue.
- Read latency: rvalid/rdata exactly 1 cycle after grant. Back-to-back grants give back-to-back rvalids.
- Reset (async): state=RUN, burst_cnt=0, owner=0. Every output is 0 except the combinational ones, which follow inputs: with no requests all are 0.
- Reset mid-operation: a pending rvalid is dropped and never delivered. Any RAM write already granted before the edge has completed.
- host_lock dropping and re-rising during FLUSH: FLUSH still lasts one cycle, then RUN → LOCK on the next edge. cpu_flush is still pulsed once.
- A fetch read granted in the cycle before lock rises still returns its fetch_rvalid during LOCK. The CPU ignores it because cpu_stall is high, and the following flush discards it.
- MAX_HOST_BURST boundary: with continuous conflict, grant pattern is MAX_HOST_BURST host grants then 1 fetch grant, repeating.

## Configuration
- IMEM_ARB_STATS_EN defined adds two outputs and their counters:
  - stat_conflicts (16-bit, saturating): counts cycles with both requesters eligible.
  - stat_host_words (16-bit, saturating): counts host writes.
  - Both clear on rst only.
- Undefined: these ports and counters do not exist. Arbitration behaviour is identical either way.

## Test plan
- Fetch-only, fetch_addr 0,1,2 on consecutive cycles, RAM preloaded 0x00000013/0x00100093/0x00200113 → fetch_gnt=1 each cycle; fetch_rvalid with those words on cycles 1,2,3; cpu_stall=0 throughout.
- Continuous conflict, MAX_HOST_BURST=8, host reads → host_gnt for 8 cycles, fetch_gnt on cycle 9, repeat. cpu_stall=1 exactly on the 8 host-won cycles.
- host_lock=1, host writes 0xDEADBEEF to addr 5, lock=0 → fetch_gnt=0 and cpu_stall=1 for the whole lock. One cycle of cpu_flush=1 follows, then fetch of addr 5 returns 0xDEADBEEF.
- Host write then read same address on next cycle → host_rvalid only for the read, data equals the written value; no fetch_rvalid.
- rst asserted mid-cycle after a fetch grant → fetch_rvalid stays 0; all outputs 0 with requests low; state RUN.
- With IMEM_ARB_STATS_EN, 70000 conflict cycles → stat_conflicts saturates at 0xFFFF.

Source files
------------

// File: rtl/imem_arbiter.sv
// imem_arbiter: single-port instruction RAM arbiter between CPU fetch and a
// host loader, with a host lock/flush sequence for rewriting program memory.
// Ports: clk/rst (async, active-high); fetch_* read port with gnt/rvalid/rdata;
// host_* read/write port with gnt/rvalid/rdata; host_lock holds the CPU;
// cpu_stall/cpu_flush control the CPU pipeline; ram_* drive the 1-cycle RAM.
// Optional stat_conflicts/stat_host_words under `define IMEM_ARB_STATS_EN.
module imem_arbiter #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter int MAX_HOST_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [DATA_W-1:0] fetch_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              host_lock,
  output logic              cpu_stall,
  output logic              cpu_flush,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_conflicts,
  output logic [15:0]       stat_host_words
`endif
);

  typedef enum logic [1:0] {RUN, LOCK, FLUSH} state_e;

  state_e     state_q, state_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic [1:0] owner_q, owner_d;

  logic fetch_elig;
  logic host_elig;

  // Fetch is masked by host_lock directly so the first lock cycle already
  // blocks the CPU, before the FSM has reached LOCK.
  always_comb begin
    fetch_elig = fetch_req & (state_q == RUN) & ~host_lock;
    host_elig  = host_req & (state_q != FLUSH);
    host_gnt   = host_elig &
                 (~fetch_elig | (burst_cnt_q < 8'(MAX_HOST_BURST)));
    fetch_gnt  = fetch_elig & ~host_gnt;
  end

  always_comb begin
    ram_en    = fetch_gnt | host_gnt;
    ram_we    = host_gnt & host_we;
    ram_addr  = '0;
    ram_wdata = '0;
    if (fetch_gnt) ram_addr = fetch_addr;
    if (host_gnt)  ram_addr = host_addr;
    if (ram_we)    ram_wdata = host_wdata;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (host_lock)  state_d = LOCK;
      LOCK:    if (!host_lock) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Burst count tracks host wins that starved a waiting fetch.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (state_q != RUN || !fetch_req || fetch_gnt)
      burst_cnt_d = '0;
    else if (host_gnt)
      burst_cnt_d = burst_cnt_q + 8'd1;
  end

  always_comb begin
    owner_d = {fetch_gnt, host_gnt & ~host_we};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      burst_cnt_q <= '0;
      owner_q     <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      owner_q     <= owner_d;
    end
  end

  always_comb begin
    fetch_rvalid = owner_q[1];
    host_rvalid  = owner_q[0];
    fetch_rdata  = owner_q[1] ? ram_rdata : '0;
    host_rdata   = owner_q[0] ? ram_rdata : '0;
    cpu_stall    = (fetch_req & ~fetch_gnt) | (state_q != RUN) | host_lock;
    cpu_flush    = (state_q == FLUSH);
  end

`ifdef IMEM_ARB_STATS_EN
  logic [15:0] stat_conflicts_q, stat_conflicts_d;
  logic [15:0] stat_host_words_q, stat_host_words_d;

  always_comb begin
    stat_conflicts_d  = stat_conflicts_q;
    stat_host_words_d = stat_host_words_q;
    if (fetch_elig && host_elig && stat_conflicts_q != 16'hFFFF)
      stat_conflicts_d = stat_conflicts_q + 16'd1;
    if (ram_we && stat_host_words_q != 16'hFFFF)
      stat_host_words_d = stat_host_words_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_conflicts_q  <= '0;
      stat_host_words_q <= '0;
    end else begin
      stat_conflicts_q  <= stat_conflicts_d;
      stat_host_words_q <= stat_host_words_d;
    end
  end

  assign stat_conflicts  = stat_conflicts_q;
  assign stat_host_words = stat_host_words_q;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: self-checking bench for imem_arbiter with a behavioural
// 4096x32 RAM, a shadow memory model and read-data scoreboard queues.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic [11:0] fetch_addr = '0;
  logic        fetch_gnt, fetch_rvalid;
  logic [31:0] fetch_rdata;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [11:0] host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic        host_gnt, host_rvalid;
  logic [31:0] host_rdata;
  logic        host_lock = 1'b0;
  logic        cpu_stall, cpu_flush;
  logic        ram_en, ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
`ifdef IMEM_ARB_STATS_EN
  logic [15:0] stat_conflicts, stat_host_words;
`endif

  int tests = 0;
  int fails = 0;

  logic [31:0] ram    [4096];
  logic [31:0] shadow [4096];
  logic [31:0] fq[$];
  logic [31:0] hq[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata     <= ram[ram_addr];
    end
  end

  imem_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_HOST_BURST(8)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt), .fetch_rvalid(fetch_rvalid),
    .fetch_rdata(fetch_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .host_lock(host_lock), .cpu_stall(cpu_stall), .cpu_flush(cpu_flush),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef IMEM_ARB_STATS_EN
    , .stat_conflicts(stat_conflicts), .stat_host_words(stat_host_words)
`endif
  );

  task automatic drive(input logic fr, input logic [11:0] fa,
                       input logic hr, input logic hw,
                       input logic [11:0] ha, input logic [31:0] hd,
                       input logic lk);
    @(posedge clk);
    #1;
    fetch_req = fr; fetch_addr = fa;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    host_lock = lk;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    fetch_req = 0; host_req = 0; host_we = 0; host_lock = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    fq.delete(); hq.delete();
  endtask

  task automatic test_reset();
    rst = 1;
    #2;
    tests++;
    if ({fetch_gnt, fetch_rvalid, host_gnt, host_rvalid, cpu_stall,
         cpu_flush, ram_en, ram_we} !== 8'h00) begin
      fails++;
      $display("FAIL reset_ctl got %b want 00000000",
               {fetch_gnt, fetch_rvalid, host_gnt, host_rvalid,
                cpu_stall, cpu_flush, ram_en, ram_we});
    end
    tests++;
    if (fetch_rdata !== 32'h0 || host_rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_rdata got %h/%h want 0/0", fetch_rdata, host_rdata);
    end
    tests++;
    if (ram_addr !== 12'h0 || ram_wdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_ram got %h/%h want 0/0", ram_addr, ram_wdata);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_fetch_only();
    logic pend = 1'b0;
    logic [31:0] exp;
    for (int k = 0; k < 4; k++) begin
      drive(logic'(k < 3), 12'(k), 0, 0, 0, 0, 0);
      if (k < 3) fq.push_back(shadow[k]);
      @(negedge clk);
      tests++;
      if (fetch_gnt !== logic'(k < 3)) begin
        fails++;
        $display("FAIL fo_gnt[%0d] got %b want %b", k, fetch_gnt, k < 3);
      end
      tests++;
      if (cpu_stall !== 1'b0) begin
        fails++;
        $display("FAIL fo_stall[%0d] got %b want 0", k, cpu_stall);
      end
      tests++;
      if (fetch_rvalid !== pend) begin
        fails++;
        $display("FAIL fo_rvalid[%0d] got %b want %b", k, fetch_rvalid, pend);
      end
      if (pend) begin
        exp = fq.pop_front();
        tests++;
        if (fetch_rdata !== exp) begin
          fails++;
          $display("FAIL fo_rdata[%0d] got %h want %h", k, fetch_rdata, exp);
        end
      end
      pend = logic'(k < 3);
    end
  endtask

  task automatic test_conflict();
    logic fpend = 1'b0, hpend = 1'b0, act, hw;
    logic [31:0] exp;
    for (int c = 0; c < 28; c++) begin
      act = logic'(c < 27);
      hw  = act & logic'((c % 9) < 8);
      drive(act, 12'd0, act, 0, 12'(100 + c), 0, 0);
      if (hw) hq.push_back(shadow[100 + c]);
      else if (act) fq.push_back(shadow[0]);
      @(negedge clk);
      tests++;
      if ({host_gnt, fetch_gnt, cpu_stall} !== {hw, act & ~hw, hw}) begin
        fails++;
        $display("FAIL cf_gnt[%0d] got h%b f%b s%b want h%b f%b s%b", c,
                 host_gnt, fetch_gnt, cpu_stall, hw, act & ~hw, hw);
      end
      tests++;
      if ({host_rvalid, fetch_rvalid} !== {hpend, fpend}) begin
        fails++;
        $display("FAIL cf_rvalid[%0d] got %b%b want %b%b", c,
                 host_rvalid, fetch_rvalid, hpend, fpend);
      end
      if (hpend) begin
        exp = hq.pop_front();
        tests++;
        if (host_rdata !== exp) begin
          fails++;
          $display("FAIL cf_hdata[%0d] got %h want %h", c, host_rdata, exp);
        end
      end
      if (fpend) begin
        exp = fq.pop_front();
        tests++;
        if (fetch_rdata !== exp) begin
          fails++;
          $display("FAIL cf_fdata[%0d] got %h want %h", c, fetch_rdata, exp);
        end
      end
      hpend = hw;
      fpend = act & ~hw;
    end
  endtask

  task automatic test_lock();
    logic [4:0] ev [7];
    logic [31:0] exp;
    // {fetch_gnt, host_gnt, cpu_stall, cpu_flush, fetch_rvalid}
    ev[0] = 5'b10000; ev[1] = 5'b01101; ev[2] = 5'b00100;
    ev[3] = 5'b00100; ev[4] = 5'b00110; ev[5] = 5'b10000;
    ev[6] = 5'b00001;
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: begin
          drive(1, 12'd5, 0, 0, 0, 0, 0);
          fq.push_back(shadow[5]);
        end
        1: begin
          drive(1, 12'd5, 1, 1, 12'd5, 32'hDEADBEEF, 1);
          shadow[5] = 32'hDEADBEEF;
        end
        2: drive(1, 12'd5, 0, 0, 0, 0, 1);
        3: drive(1, 12'd5, 0, 0, 0, 0, 0);
        4: drive(1, 12'd5, 1, 0, 12'd5, 0, 0);
        5: begin
          drive(1, 12'd5, 0, 0, 0, 0, 0);
          fq.push_back(shadow[5]);
        end
        default: drive(0, 0, 0, 0, 0, 0, 0);
      endcase
      @(negedge clk);
      tests++;
      if ({fetch_gnt, host_gnt, cpu_stall, cpu_flush, fetch_rvalid}
          !== ev[c]) begin
        fails++;
        $display("FAIL lk_ctl[%0d] got %b want %b", c,
                 {fetch_gnt, host_gnt, cpu_stall, cpu_flush, fetch_rvalid},
                 ev[c]);
      end
      if (ev[c][0]) begin
        exp = fq.pop_front();
        tests++;
        if (fetch_rdata !== exp) begin
          fails++;
          $display("FAIL lk_rdata[%0d] got %h want %h", c, fetch_rdata, exp);
        end
      end
      if (c == 1) begin
        tests++;
        if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 12'd5, 32'hDEADBEEF}) begin
          fails++;
          $display("FAIL lk_write got %b %h %h want 1 005 deadbeef",
                   ram_we, ram_addr, ram_wdata);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    drive(0, 0, 1, 1, 12'd7, 32'h12345678, 0);
    shadow[7] = 32'h12345678;
    @(negedge clk);
    tests++;
    if ({host_gnt, ram_we, ram_addr, ram_wdata, host_rvalid}
        !== {1'b1, 1'b1, 12'd7, 32'h12345678, 1'b0}) begin
      fails++;
      $display("FAIL bb_wr got g%b we%b %h %h rv%b want g1 we1 007 12345678 rv0",
               host_gnt, ram_we, ram_addr, ram_wdata, host_rvalid);
    end
    drive(0, 0, 1, 0, 12'd7, 0, 0);
    hq.push_back(shadow[7]);
    @(negedge clk);
    tests++;
    if ({host_gnt, ram_we, host_rvalid, fetch_rvalid} !== 4'b1000) begin
      fails++;
      $display("FAIL bb_rd got %b want 1000",
               {host_gnt, ram_we, host_rvalid, fetch_rvalid});
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    exp = hq.pop_front();
    tests++;
    if ({host_rvalid, fetch_rvalid, host_rdata} !== {2'b10, exp}) begin
      fails++;
      $display("FAIL bb_data got rv%b%b %h want rv10 %h",
               host_rvalid, fetch_rvalid, host_rdata, exp);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 12'd9, 0, 0, 0, 0, 0);
    @(negedge clk);
    tests++;
    if (fetch_gnt !== 1'b1) begin
      fails++;
      $display("FAIL rm_gnt got %b want 1", fetch_gnt);
    end
    #1;
    rst = 1;
    fetch_req = 0;
    @(posedge clk);
    #1;
    tests++;
    if ({fetch_gnt, fetch_rvalid, host_gnt, host_rvalid, cpu_stall,
         cpu_flush, ram_en, ram_we} !== 8'h00 || fetch_rdata !== 32'h0) begin
      fails++;
      $display("FAIL rm_outs got %b %h want 00000000 0",
               {fetch_gnt, fetch_rvalid, host_gnt, host_rvalid, cpu_stall,
                cpu_flush, ram_en, ram_we}, fetch_rdata);
    end
    @(negedge clk);
    rst = 0;
    drive(1, 12'd1, 0, 0, 0, 0, 0);
    @(negedge clk);
    tests++;
    if ({fetch_gnt, cpu_stall, cpu_flush, fetch_rvalid} !== 4'b1000) begin
      fails++;
      $display("FAIL rm_run got %b want 1000",
               {fetch_gnt, cpu_stall, cpu_flush, fetch_rvalid});
    end
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

`ifdef IMEM_ARB_STATS_EN
  task automatic test_stats();
    apply_reset();
    for (int i = 0; i < 10; i++) drive(1, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tests++;
    if (stat_conflicts !== 16'd10) begin
      fails++;
      $display("FAIL st_cnt got %0d want 10", stat_conflicts);
    end
    for (int i = 0; i < 70000; i++) drive(1, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tests++;
    if (stat_conflicts !== 16'hFFFF || stat_host_words !== 16'h0) begin
      fails++;
      $display("FAIL st_sat got %h/%h want ffff/0000",
               stat_conflicts, stat_host_words);
    end
  endtask
`endif

  initial begin
    for (int a = 0; a < 4096; a++) begin
      shadow[a] = 32'h5A000000 | 32'(a);
    end
    shadow[0] = 32'h00000013;
    shadow[1] = 32'h00100093;
    shadow[2] = 32'h00200113;
    for (int a = 0; a < 4096; a++) ram[a] = shadow[a];
    test_reset();
    test_fetch_only();
    test_conflict();
    test_lock();
    test_back_to_back();
    test_reset_mid();
`ifdef IMEM_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
